// File: rtl/accel_poll_ctrl_pkg.sv
// Shared types and BMA280 register constants for the accelerometer poll controller.
package accel_poll_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG_RANGE,
        CFG_BW,
        POLL_WAIT,
        RD_BYTE,
        PUBLISH,
        RECOVER
    } state_e;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT_END,
        RELEASE
    } phase_e;

    localparam logic [7:0] BMA280_PMU_RANGE  = 8'h0F;
    localparam logic [7:0] BMA280_PMU_BW     = 8'h10;
    localparam logic [7:0] BMA280_ACCD_X_LSB = 8'h02;
    localparam logic [7:0] DEF_RANGE_VAL     = 8'h03;
    localparam logic [7:0] DEF_BW_VAL        = 8'h0C;

    localparam int NUM_DATA_BYTES = 6;

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    function automatic logic [7:0] byte_addr(input logic [7:0] base, input logic [2:0] idx);
        return base + {5'd0, idx};
    endfunction

    // LSB register carries the low 6 data bits in [7:2]; only those are kept.
    function automatic logic [13:0] axis_value(input logic [7:0] msb, input logic [5:0] lsb6);
        return {msb, lsb6};
    endfunction

endpackage

// File: rtl/accel_poll_ctrl_if.sv
// Request/complete handshake between the poll controller and the I2C master.
interface accel_poll_ctrl_if;
    logic       start_r_w;
    logic       r_w;
    logic [7:0] reg_addr;
    logic [7:0] data_write;
    logic [7:0] data_read;
    logic       end_r_w;

    modport master (
        output start_r_w, r_w, reg_addr, data_write,
        input  data_read, end_r_w
    );

    modport slave (
        input  start_r_w, r_w, reg_addr, data_write,
        output data_read, end_r_w
    );
endinterface

// File: rtl/accel_poll_timer.sv
// Poll period counter: load restarts a POLL_DIV-cycle countdown, expire pulses when it ends.
module accel_poll_timer #(
    parameter int POLL_DIV = 10400
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);
    localparam int W = $clog2(POLL_DIV + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(POLL_DIV);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == W'(1));
endmodule

// File: rtl/accel_poll_ctrl.sv
// Configures a BMA280 over an I2C master, then periodically reads the six data
// registers and publishes coherent x/y/z samples.
module accel_poll_ctrl
    import accel_poll_ctrl_pkg::*;
#(
    parameter int         POLL_DIV  = 10400,
    parameter int         TIMEOUT   = 4095,
    parameter logic [7:0] RANGE_REG = BMA280_PMU_RANGE,
    parameter logic [7:0] RANGE_VAL = DEF_RANGE_VAL,
    parameter logic [7:0] BW_REG    = BMA280_PMU_BW,
    parameter logic [7:0] BW_VAL    = DEF_BW_VAL,
    parameter logic [7:0] DATA_BASE = BMA280_ACCD_X_LSB
) (
    input  logic                i2c_clk,
    input  logic                RSTn,
    input  logic                enable,
    accel_poll_ctrl_if.master   io,
    output logic signed [13:0]  accel_x,
    output logic signed [13:0]  accel_y,
    output logic signed [13:0]  accel_z,
    output logic                sample_valid,
    output logic                busy,
    output logic                error
);
    localparam int         TW       = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_DATA_BYTES - 1);

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [2:0]        idx_q, idx_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              rec_q, rec_d;
    logic              due_q, due_d;
    logic              start_q, start_d, r_w_q, r_w_d;
    logic [7:0]        addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0][5:0]   lsb_q, lsb_d;
    logic [2:0][7:0]   msb_q, msb_d;
    logic [13:0]       ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic              valid_q, valid_d, busy_q, busy_d, error_q, error_d;
    logic              timer_load, poll_expire, issue;
    txn_t              txn;

    accel_poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
        .clk    (i2c_clk),
        .rst_n  (RSTn),
        .load   (timer_load),
        .expire (poll_expire)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        rec_d      = rec_q;
        due_d      = due_q | poll_expire;
        start_d    = start_q;
        r_w_d      = r_w_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lsb_d      = lsb_q;
        msb_d      = msb_q;
        ax_d       = ax_q;
        ay_d       = ay_q;
        az_d       = az_q;
        valid_d    = 1'b0;
        error_d    = error_q;
        timer_load = 1'b0;
        issue      = 1'b0;
        txn        = '0;

        case (state_q)
            IDLE: begin
                due_d = 1'b0;
                if (enable) begin
                    state_d = CFG_RANGE;
                    issue   = 1'b1;
                    txn     = '{rd: 1'b0, addr: RANGE_REG, data: RANGE_VAL};
                end
            end
            CFG_RANGE, CFG_BW, RD_BYTE: begin
                // Completion beats timeout when both land in the same cycle.
                if (phase_q == RELEASE) begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (state_q == CFG_RANGE) begin
                        state_d = CFG_BW;
                        issue   = 1'b1;
                        txn     = '{rd: 1'b0, addr: BW_REG, data: BW_VAL};
                    end else if (state_q == CFG_BW) begin
                        state_d = POLL_WAIT;
                        due_d   = 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = PUBLISH;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        issue = 1'b1;
                        txn   = '{rd: 1'b1, addr: byte_addr(DATA_BASE, idx_q + 3'd1), data: 8'h00};
                    end
                end else if (io.end_r_w) begin
                    start_d = 1'b0;
                    phase_d = RELEASE;
                    if (state_q == RD_BYTE) begin
                        if (idx_q[0]) msb_d[idx_q[2:1]] = io.data_read;
                        else          lsb_d[idx_q[2:1]] = io.data_read[7:2];
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    start_d = 1'b0;
                    error_d = 1'b1;
                    rec_d   = 1'b0;
                    state_d = RECOVER;
                end else begin
                    tmo_d   = tmo_q + TW'(1);
                    phase_d = WAIT_END;
                end
            end
            POLL_WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (due_q || poll_expire) begin
                    state_d    = RD_BYTE;
                    idx_d      = 3'd0;
                    due_d      = 1'b0;
                    timer_load = 1'b1;
                    issue      = 1'b1;
                    txn        = '{rd: 1'b1, addr: DATA_BASE, data: 8'h00};
                end
            end
            PUBLISH: begin
                ax_d    = axis_value(msb_q[0], lsb_q[0]);
                ay_d    = axis_value(msb_q[1], lsb_q[1]);
                az_d    = axis_value(msb_q[2], lsb_q[2]);
                valid_d = 1'b1;
                error_d = 1'b0;
                state_d = POLL_WAIT;
            end
            RECOVER: begin
                if (!rec_q) begin
                    rec_d = 1'b1;
                end else begin
                    rec_d = 1'b0;
                    if (enable) begin
                        state_d = CFG_RANGE;
                        issue   = 1'b1;
                        txn     = '{rd: 1'b0, addr: RANGE_REG, data: RANGE_VAL};
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            start_d = 1'b1;
            phase_d = ISSUE;
            tmo_d   = '0;
            r_w_d   = txn.rd;
            addr_d  = txn.addr;
            wdata_d = txn.data;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i2c_clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            phase_q <= ISSUE;
            idx_q   <= '0;
            tmo_q   <= '0;
            rec_q   <= 1'b0;
            due_q   <= 1'b0;
            start_q <= 1'b0;
            r_w_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lsb_q   <= '0;
            msb_q   <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            az_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            rec_q   <= rec_d;
            due_q   <= due_d;
            start_q <= start_d;
            r_w_q   <= r_w_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lsb_q   <= lsb_d;
            msb_q   <= msb_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            az_q    <= az_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    assign io.start_r_w  = start_q;
    assign io.r_w        = r_w_q;
    assign io.reg_addr   = addr_q;
    assign io.data_write = wdata_q;
    assign accel_x       = ax_q;
    assign accel_y       = ay_q;
    assign accel_z       = az_q;
    assign sample_valid  = valid_q;
    assign busy          = busy_q;
    assign error         = error_q;
endmodule

// File: tb/tb_accel_poll_ctrl.sv
// Scoreboard bench for accel_poll_ctrl: an I2C master model answers requests while
// monitors compare completed transactions and published samples against queued expectations.
module tb_accel_poll_ctrl;
    localparam int POLL_DIV = 50;
    localparam int TIMEOUT  = 100;

    localparam logic [41:0] S1 = {14'h0041, 14'h3FFF, 14'h2000};
    localparam logic [41:0] S2 = {14'h1FFF, 14'h0000, 14'h04AA};
    localparam logic [47:0] SET1 = 48'h80_00_FF_FC_01_04;
    localparam logic [47:0] SET2 = 48'h12_A8_00_00_7F_FF;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic signed [13:0] accel_x, accel_y, accel_z;
    logic sample_valid, busy, error;

    accel_poll_ctrl_if bus ();

    accel_poll_ctrl #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)) dut (
        .i2c_clk      (clk),
        .RSTn         (rst_n),
        .enable       (enable),
        .io           (bus),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .sample_valid (sample_valid),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [16:0] txn_q[$];
    logic [41:0] smp_q[$];
    logic [7:0]  mem [8];
    int          ack_delay = 30;
    bit          drop_en   = 1'b0;

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic en_v);
        tick();
        rst_n  = rst_v;
        enable = en_v;
    endtask

    task automatic setMem(input logic [47:0] b);
        for (int i = 0; i < 6; i++) mem[2+i] = b[8*i +: 8];
    endtask

    function automatic logic [16:0] wr(input logic [7:0] a, input logic [7:0] d);
        return {1'b0, a, d};
    endfunction

    function automatic logic [16:0] rd(input logic [7:0] a);
        return {1'b1, a, 8'h00};
    endfunction

    task automatic pushCfg();
        txn_q.push_back(wr(8'h0F, 8'h03));
        txn_q.push_back(wr(8'h10, 8'h0C));
    endtask

    task automatic pushReads(input int n);
        for (int i = 0; i < n; i++) txn_q.push_back(rd(8'h02 + 8'(i)));
    endtask

    task automatic pushPoll(input logic [41:0] smp);
        pushReads(6);
        smp_q.push_back(smp);
    endtask

    task automatic waitStart(input string name, input logic [7:0] addr);
        int n = 0;
        do begin tick(); n++; end
        while (!(bus.start_r_w && bus.reg_addr == addr) && n < 2000);
        checkOutput(name, {bus.start_r_w, bus.reg_addr}, {1'b1, addr});
    endtask

    task automatic waitSample(input string name);
        int n = 0;
        do begin tick(); n++; end
        while (!sample_valid && n < 2000);
        checkOutput(name, sample_valid, 1'b1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_bus"}, {bus.start_r_w, bus.r_w, bus.reg_addr, bus.data_write}, 18'h0);
        checkOutput({tag, "_accel"}, {accel_x, accel_y, accel_z}, 42'h0);
        checkOutput({tag, "_flags"}, {sample_valid, busy, error}, 3'b000);
    endtask

    // I2C master model: acks ack_delay cycles after start_r_w rises unless told to hang.
    initial begin
        int hi = 0;
        bus.end_r_w   = 1'b0;
        bus.data_read = 8'h00;
        forever begin
            @(negedge clk);
            if (!bus.start_r_w || bus.end_r_w) begin
                hi          = 0;
                bus.end_r_w = 1'b0;
            end else begin
                hi++;
                if (hi == ack_delay && !(drop_en && bus.r_w && bus.reg_addr == 8'h04)) begin
                    bus.end_r_w   = 1'b1;
                    bus.data_read = bus.r_w ? mem[bus.reg_addr[2:0]] : 8'h00;
                end
            end
        end
    end

    initial begin
        logic [16:0] exp;
        forever begin
            tick();
            if (bus.start_r_w && bus.end_r_w) begin
                exp = (txn_q.size() != 0) ? txn_q.pop_front() : 17'h1FFFF;
                checkOutput("txn", {bus.r_w, bus.reg_addr, bus.data_write}, exp);
            end
        end
    end

    initial begin
        logic [42:0] exp;
        forever begin
            tick();
            if (sample_valid) begin
                exp = (smp_q.size() != 0) ? {smp_q.pop_front(), 1'b0} : 43'h7FF_FFFF_FFFF;
                checkOutput("sample", {accel_x, accel_y, accel_z, error}, exp);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        enable = 1'b0;
        setMem(SET1);
        repeat (3) tick();
        checkResetState("reset");

        // Configuration then the first poll.
        pushCfg();
        pushPoll(S1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        n = 0;
        do begin tick(); n++; end while (!bus.end_r_w && n < 200);
        checkOutput("cfg_range_end", bus.end_r_w, 1'b1);
        checkOutput("busy_cfg", busy, 1'b1);
        n = 0;
        do begin tick(); if (!bus.start_r_w) n++; end while (!bus.start_r_w && n < 10);
        checkOutput("cfg_release_width", n, 1);
        checkOutput("cfg_bw_issue", {bus.r_w, bus.reg_addr, bus.data_write}, {1'b0, 8'h10, 8'h0C});
        waitSample("poll1_sample");

        // Third read hangs: timeout, recovery, reconfiguration, fresh poll.
        drop_en = 1'b1;
        pushReads(2);
        pushCfg();
        pushPoll(S2);
        waitStart("hang_start", 8'h04);
        n = 1;
        do begin tick(); if (bus.start_r_w) n++; end while (bus.start_r_w && n < 500);
        checkOutput("timeout_len", n, TIMEOUT);
        checkOutput("error_set", error, 1'b1);
        drop_en = 1'b0;
        setMem(SET2);
        n = 1;
        do begin tick(); if (!bus.start_r_w) n++; end while (!bus.start_r_w && n < 10);
        checkOutput("recover_width", n, 2);
        checkOutput("recover_cfg", {bus.r_w, bus.reg_addr, bus.data_write}, {1'b0, 8'h0F, 8'h03});
        waitStart("poll3_last", 8'h07);
        checkOutput("error_held", error, 1'b1);
        waitSample("poll3_sample");

        // Short transactions against a short period: polls run back to back.
        ack_delay = 20;
        for (int k = 0; k < 3; k++) begin
            pushPoll(S2);
            tick();
            checkOutput("b2b_start", {bus.start_r_w, bus.r_w, bus.reg_addr}, {1'b1, 1'b1, 8'h02});
            waitSample("b2b_sample");
            checkOutput("b2b_txn_drained", txn_q.size(), 0);
        end

        // Enable drops mid-poll: current read finishes, nothing published.
        pushReads(4);
        waitStart("drop_byte3", 8'h05);
        enable = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.start_r_w && n < 100);
        repeat (3) tick();
        checkOutput("drop_idle", {busy, bus.start_r_w}, 2'b00);
        checkOutput("drop_hold_sample", {accel_x, accel_y, accel_z}, S2);
        checkOutput("drop_txn_drained", txn_q.size(), 0);
        repeat (2 * POLL_DIV) tick();
        checkOutput("drop_quiet", {busy, bus.start_r_w, sample_valid}, 3'b000);

        // Reset while a request is outstanding.
        setMem(SET1);
        pushCfg();
        pushPoll(S1);
        applyStimulus(1'b1, 1'b1);
        waitStart("pre_reset_start", 8'h0F);
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_async_start", bus.start_r_w, 1'b0);
        checkResetState("midreset");
        repeat (3) tick();
        applyStimulus(1'b1, 1'b1);
        waitSample("after_reset_sample");
        enable = 1'b0;
        repeat (5) tick();
        checkOutput("final_idle", {busy, bus.start_r_w}, 2'b00);
        checkOutput("txn_q_empty", txn_q.size(), 0);
        checkOutput("smp_q_empty", smp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
